// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the pipeline stage register with skid buffer.
// Control bundle field offsets follow the EX/MEM control layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int DEF_CTRL_W    = 13;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_WORDS = 6;
  localparam int DEF_REG_W     = 5;
  localparam int DEF_CNT_W     = 16;

  // LSB offset of each control field; field widths are listed alongside.
  localparam int CTRL_BRANCH   = 0;   // 2 bits
  localparam int CTRL_JUMP     = 2;   // 2 bits
  localparam int CTRL_MEMTOREG = 4;   // 2 bits
  localparam int CTRL_REGWRITE = 6;   // 1 bit
  localparam int CTRL_MEMWRITE = 7;   // 2 bits
  localparam int CTRL_MEMREAD  = 9;   // 2 bits
  localparam int CTRL_ZERO     = 11;  // 1 bit
  localparam int CTRL_JR       = 12;  // 1 bit

  function automatic int entry_width(input int ctrl_w, input int reg_w, input int pay_w);
    return ctrl_w + reg_w + pay_w;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream and downstream valid/ready handshake bundle of one pipeline stage.
interface pipe_stage_skid_if #(
  parameter int CTRL_W    = pipe_pkg::DEF_CTRL_W,
  parameter int DATA_W    = pipe_pkg::DEF_DATA_W,
  parameter int NUM_WORDS = pipe_pkg::DEF_NUM_WORDS,
  parameter int REG_W     = pipe_pkg::DEF_REG_W
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [CTRL_W-1:0]           in_ctrl;
  logic [NUM_WORDS*DATA_W-1:0] in_data;
  logic [REG_W-1:0]            in_rd;

  logic                        out_valid;
  logic                        out_ready;
  logic [CTRL_W-1:0]           out_ctrl;
  logic [NUM_WORDS*DATA_W-1:0] out_data;
  logic [REG_W-1:0]            out_rd;

  // Environment side: drives the producer signals and the consumer's ready.
  modport master (
    output in_valid, in_ctrl, in_data, in_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, out_rd
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, in_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, out_rd
  );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer, flush and stall counter.
// in_ready comes only from registered state, breaking the ready path upstream.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int REG_W     = DEF_REG_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_skid_if.slave bus,
  input  logic             flush,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PAY_W   = NUM_WORDS * DATA_W;
  localparam int ENTRY_W = entry_width(CTRL_W, REG_W, PAY_W);

  state_e               state_q;
  state_e               state_d;
  logic [ENTRY_W-1:0]   main_q;
  logic [ENTRY_W-1:0]   main_d;
  logic [ENTRY_W-1:0]   skid_q;
  logic [ENTRY_W-1:0]   skid_d;
  logic [ENTRY_W-1:0]   in_entry_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 out_valid_s;
  logic                 in_ready_s;

  assign in_entry_s  = {bus.in_ctrl, bus.in_rd, bus.in_data};
  assign out_valid_s = (state_q != EMPTY);
  assign in_ready_s  = (state_q != TWO);
  assign in_fire_s   = bus.in_valid & in_ready_s;
  assign out_fire_s  = out_valid_s & bus.out_ready;

  // Next-state and entry load decisions; flush overrides every load.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_s) begin
          main_d  = in_entry_s;
          state_d = ONE;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && out_fire_s) begin
          main_d  = in_entry_s;
          state_d = ONE;
        end else if (in_fire_s) begin
          skid_d  = in_entry_s;
          state_d = TWO;
        end else if (out_fire_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (out_fire_s) begin
          main_d  = skid_q;
          state_d = ONE;
        end else begin
          state_d = TWO;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and entry registers; payload of empty entries is left stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= {ENTRY_W{1'b0}};
      skid_q  <= {ENTRY_W{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Bubbles present zero control and rd so a squashed slot never writes state.
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = main_q[PAY_W-1:0];
  assign bus.out_rd    = out_valid_s ? main_q[PAY_W +: REG_W] : {REG_W{1'b0}};
  assign bus.out_ctrl  = out_valid_s ? main_q[PAY_W+REG_W +: CTRL_W] : {CTRL_W{1'b0}};

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid_s & ~bus.out_ready),
    .clr_i (clr_stats),
    .cnt_o (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter. It is the next-generation replacement for the fixed, always-loading inter-stage registers (ID/EX, EX/MEM, MEM/WB) in the pipelined CPU. It lets any stage stall or squash without dropping or duplicating an instruction. Control bits of a bubble are forced to zero, so a squashed slot can never write the register file or memory.

## Interface
Parameters:
- CTRL_W, 13, width of the control bundle (branch, jump, mem-to-reg, reg-write, mem-write, mem-read, zero, jr)
- DATA_W, 32, width of one payload word
- NUM_WORDS, 6, number of payload words carried
- REG_W, 5, destination register index width
- CNT_W, 16, stall counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  stage clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bundle
- in_data  in  NUM_WORDS*DATA_W  payload words, word 0 in LSBs
- in_rd  in  REG_W  destination register
- flush  in  1  squash all held entries and this cycle's input
- out_valid  out  1  stage holds an instruction for downstream
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0
- out_data  out  NUM_WORDS*DATA_W  payload of head entry
- out_rd  out  REG_W  destination register of head entry; zero whenever out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- clr_stats  in  1  synchronous clear of stall_cnt

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (head, drives outputs) and skid entry. Order is strictly FIFO.
- States: EMPTY, ONE (main full), TWO (main and skid full). in_ready = (state != TWO). out_valid = (state != EMPTY).
- EMPTY: in_fire → main←in, go to ONE.
- ONE: in_fire & out_fire → main←in, stay in ONE. in_fire & !out_fire → skid←in, go to TWO. !in_fire & out_fire → go to EMPTY.
- TWO: out_fire → main←skid, go to ONE. No input is accepted.
- flush (highest priority after rst) → go to EMPTY next cycle and discard the in_fire data of that cycle. An out_fire in the flush cycle still completes downstream.
- The payload registers of empty entries hold stale data. Output gating of ctrl and rd is applied combinationally from out_valid.
- stall_cnt: +1 per cycle with out_valid & !out_ready; holds at 2^CNT_W−1. rst or clr_stats sets it to 0. clr_stats has priority over increment.

## Timing
- Reset: state=EMPTY, stall_cnt=0, out_valid=0, out_ctrl=0, out_rd=0, out_data=0, in_ready=1 the cycle after rst deasserts. Inputs presented while rst=1 are discarded.
- Latency: an input accepted at edge N is visible at outputs after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready depends only on registered state. It has no combinational path from out_ready, which is the purpose of the skid entry.
- Backpressure: one extra instruction is absorbed after out_ready falls. in_ready drops in the cycle after the skid entry fills.
- Simultaneous flush and in_fire: input is dropped. Simultaneous flush and rst: rst wins, with identical result.

## Structure
- Package pipe_pkg: state enum (EMPTY, ONE, TWO), default widths, and field offset constants for the EX/MEM control bundle (BRANCH, JUMP, MEMTOREG, REGWRITE, MEMWRITE, MEMREAD, ZERO, JR).
- One sub-module: sat_counter (CNT_W, inc, clr) for stall_cnt.
- Entries are stored as packed {ctrl, rd, data} vectors.

## Test plan
- Streaming: out_ready=1, send in_data words 0x1..0x6, 0x11..0x16, 0x21..0x26 on 3 consecutive cycles → same three appear on out_data on the following 3 cycles, in order; stall_cnt=0.
- Skid: hold out_ready=0 and send A and B back-to-back → in_ready=0 after B, stall_cnt counts. Release out_ready → A then B, no loss or duplication.
- Flush in TWO with in_valid=1 carrying C → next cycle out_valid=0, out_ctrl=0, out_rd=0, in_ready=1. C is never output.
- Bubble gating: after flush, in_ctrl had REGWRITE=1 and MEMWRITE=2'b11 → out_ctrl remains 13'h0 while out_valid=0.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cnt=15. Pulse clr_stats while still stalled → 0, then 1 on the next cycle.
- Reset mid-operation: assert rst in TWO → next cycle state EMPTY, all outputs at reset values, and the prior entries are never emitted.
